// File: rtl/bcd_down_timer_if.sv
// rtl/bcd_down_timer_if.sv - control and status bundle for the BCD down timer
interface bcd_down_timer_if;
  logic       load;
  logic [7:0] din;
  logic       start;
  logic       pause;
  logic       tick;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output load, din, start, pause, tick,
    input  q, busy, done, err
  );

  modport slave (
    input  load, din, start, pause, tick,
    output q, busy, done, err
  );
endinterface

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - two-digit packed-BCD down counter with pause and optional auto reload
module bcd_down_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic              clk,
  input  logic              res,
  bcd_down_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] q_q, q_d;
  logic [7:0] reload_q, reload_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  // Both nibbles must be decimal digits for a preset to be accepted.
  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Decrement a nonzero packed BCD value, borrowing from tens when ones is 0.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      return {v[7:4] - 4'd1, 4'd9};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Next-state, count, reload, error and terminal-count pulse decode.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (bcd_ok(bus.din)) begin
            q_d      = bus.din;
            reload_d = bus.din;
            err_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.start) begin
          if (q_q != 8'h00) begin
            state_d = RUN;
          end else begin
            // A held START at zero must not stretch DONE into back-to-back cycles.
            done_d = ~done_q;
          end
        end
      end
      RUN: begin
        if (bus.pause) begin
          state_d = PAUSED;
        end else if (bus.tick) begin
          if (q_q == 8'h00) begin
            // Only reachable with auto reload: the pass after terminal count restarts.
            q_d = reload_q;
          end else begin
            q_d = bcd_dec(q_q);
            if (q_q == 8'h01) begin
              done_d = 1'b1;
              if (!AUTO_RELOAD) begin
                state_d = IDLE;
              end
            end
          end
        end
      end
      PAUSED: begin
        if (bus.start && !bus.pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset overrides every control input.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      q_q      <= 8'h00;
      reload_q <= 8'h00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - scoreboard bench for the BCD down timer in both reload modes
module tb_bcd_down_timer;

  logic clk = 1'b0;
  logic res;

  always #5 clk = ~clk;

  bcd_down_timer_if if0();
  bcd_down_timer_if if1();

  bcd_down_timer #(.AUTO_RELOAD(1'b0)) u_dut0 (
    .clk (clk),
    .res (res),
    .bus (if0.slave)
  );

  bcd_down_timer #(.AUTO_RELOAD(1'b1)) u_dut1 (
    .clk (clk),
    .res (res),
    .bus (if1.slave)
  );

  typedef struct packed {
    logic [7:0]  q;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] tag;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic cmp(input int sel, input int id, input string name,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d step %0d %s: got %h expected %h", sel, id, name, act, exp);
    end
  endtask

  // Monitor: outputs are compared at every falling edge that has a pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      cmp(0, int'(e.tag), "q",    if0.q,           e.q);
      cmp(0, int'(e.tag), "busy", {7'd0, if0.busy}, {7'd0, e.busy});
      cmp(0, int'(e.tag), "done", {7'd0, if0.done}, {7'd0, e.done});
      cmp(0, int'(e.tag), "err",  {7'd0, if0.err},  {7'd0, e.err});
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      cmp(1, int'(e.tag), "q",    if1.q,           e.q);
      cmp(1, int'(e.tag), "busy", {7'd0, if1.busy}, {7'd0, e.busy});
      cmp(1, int'(e.tag), "done", {7'd0, if1.done}, {7'd0, e.done});
      cmp(1, int'(e.tag), "err",  {7'd0, if1.err},  {7'd0, e.err});
    end
  end

  // Drive one cycle of inputs to the selected DUT and queue the state expected after the edge.
  task automatic step(input int sel, input logic r, input logic ld, input logic [7:0] d,
                      input logic st, input logic ps, input logic tk,
                      input logic [7:0] eq, input logic eb, input logic ed, input logic ee);
    exp_t e;
    @(negedge clk);
    #1;
    res       = r;
    if0.load  = (sel == 0) ? ld : 1'b0;
    if0.din   = (sel == 0) ? d  : 8'h00;
    if0.start = (sel == 0) ? st : 1'b0;
    if0.pause = (sel == 0) ? ps : 1'b0;
    if0.tick  = (sel == 0) ? tk : 1'b0;
    if1.load  = (sel == 1) ? ld : 1'b0;
    if1.din   = (sel == 1) ? d  : 8'h00;
    if1.start = (sel == 1) ? st : 1'b0;
    if1.pause = (sel == 1) ? ps : 1'b0;
    if1.tick  = (sel == 1) ? tk : 1'b0;
    tag++;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    e.err  = ee;
    e.tag  = 16'(tag);
    if (sel == 0) sb0.push_back(e);
    else          sb1.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b1;
    if0.load = 1'b0; if0.din = 8'h00; if0.start = 1'b0; if0.pause = 1'b0; if0.tick = 1'b0;
    if1.load = 1'b0; if1.din = 8'h00; if1.start = 1'b0; if1.pause = 1'b0; if1.tick = 1'b0;

    // Reset, including control inputs active on the reset edge.
    step(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 1, 8'h45, 1, 0, 1, 8'h00, 0, 0, 0);

    // Count 12 down to 00 with TICK held high.
    step(0, 0, 1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0, 0, 8'h12, 1, 0, 0);
    for (int n = 11; n >= 1; n--) begin
      step(0, 0, 0, 8'h00, 0, 0, 1, bcd(n), 1, 0, 0);
    end
    step(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 0);
    step(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0);

    // Invalid and valid loads; LOAD wins over START in IDLE.
    step(0, 0, 1, 8'h3A, 0, 0, 0, 8'h00, 0, 0, 1);
    step(0, 0, 1, 8'h05, 0, 0, 0, 8'h05, 0, 0, 0);
    step(0, 0, 1, 8'hA0, 0, 0, 0, 8'h05, 0, 0, 1);
    step(0, 0, 1, 8'h20, 1, 0, 0, 8'h20, 0, 0, 0);

    // Pause / resume from 20, with LOAD and START ignored where they should be.
    step(0, 0, 0, 8'h00, 1, 0, 0, 8'h20, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 1, 1, 8'h20, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 1, 8'h20, 1, 0, 0);
    step(0, 0, 0, 8'h00, 1, 1, 1, 8'h20, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 1, 8'h20, 1, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0, 0, 8'h20, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 1, 8'h19, 1, 0, 0);
    step(0, 0, 1, 8'h55, 1, 0, 0, 8'h19, 1, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0, 1, 8'h18, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 1, 1, 8'h18, 1, 0, 0);
    step(0, 0, 1, 8'h33, 0, 0, 0, 8'h18, 1, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0, 0, 8'h18, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 1, 8'h17, 1, 0, 0);

    // Reset in RUN at 07 aborts without DONE.
    step(0, 1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0);
    step(0, 0, 1, 8'h07, 0, 0, 0, 8'h07, 0, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0, 0, 8'h07, 1, 0, 0);
    step(0, 1, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0);

    // Reset in PAUSED, and reset clearing a sticky ERR.
    step(0, 0, 1, 8'h03, 0, 0, 0, 8'h03, 0, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0, 0, 8'h03, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 1, 0, 8'h03, 1, 0, 0);
    step(0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 1, 8'h3A, 0, 0, 0, 8'h00, 0, 0, 1);
    step(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    // START at 00: one DONE pulse, never two in a row, BUSY stays low.
    step(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0);
    step(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    // Auto-reload instance: 02,01,00,02,01,00,02 then pause.
    step(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 1, 8'h02, 0, 0, 0, 8'h02, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 0, 0, 8'h02, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 1, 1, 0);
    step(1, 0, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 1, 1, 0);
    step(1, 0, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 1, 1, 8'h02, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0);

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (sb0.size() + sb1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb0.size() + sb1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter AUTO_RELOAD, default 0; when 1, the block SHALL reload and restart on terminal count.
REQ-002 CLK  in  1  system clock; all state SHALL update on the rising edge.
REQ-003 RES  in  1  reset, synchronous and active-high.
REQ-004 LOAD  in  1  load request; DIN is sampled on the same edge.
REQ-005 DIN  in  8  preset value, two packed BCD digits {tens[7:4], ones[3:0]}.
REQ-006 START  in  1  start or resume request.
REQ-007 PAUSE  in  1  pause request.
REQ-008 TICK  in  1  count strobe; one decrement per cycle with TICK=1 while running.
REQ-009 Q  out  8  current count, packed BCD {tens, ones}, registered.
REQ-010 BUSY  out  1  high while the state is RUN or PAUSED.
REQ-011 DONE  out  1  one-cycle terminal-count pulse, registered.
REQ-012 ERR  out  1  sticky flag for an invalid-BCD load.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and PAUSED.
REQ-014 A reload register SHALL hold the last valid preset value.
REQ-015 IDLE with LOAD=1 and both DIN nibbles <= 9: on that edge, Q and the reload register SHALL take DIN, and ERR SHALL clear.
REQ-016 IDLE with LOAD=1 and either DIN nibble > 9: on that edge, Q and the reload register SHALL hold, and ERR SHALL set.
REQ-017 LOAD SHALL be ignored in RUN and PAUSED.
REQ-018 In IDLE, LOAD SHALL take priority over START on the same edge; START is then ignored.
REQ-019 IDLE with START=1 and LOAD=0:
  - Q != 00: go to RUN on that edge.
  - Q == 00: stay in IDLE and pulse DONE for the next cycle.
REQ-020 RUN with TICK=1 and PAUSE=0: Q SHALL decrement in BCD on that edge; the new value is visible in the following cycle (latency 1).
  - ones > 0: ones - 1.
  - ones == 0: ones becomes 9 and tens - 1.
REQ-021 RUN, Q == 01, TICK=1: Q SHALL become 00 and DONE SHALL be high for exactly the next cycle.
  - AUTO_RELOAD=0: go to IDLE on the same edge.
  - AUTO_RELOAD=1: stay in RUN and, on the next TICK, take the reload register value instead of decrementing.
REQ-022 In RUN, TICK SHALL be ignored whenever PAUSE=1 on the same edge.
REQ-023 RUN with PAUSE=1: go to PAUSED; Q SHALL hold.
REQ-024 PAUSED SHALL ignore TICK.
REQ-025 PAUSED with START=1 and PAUSE=0: go to RUN; decrementing resumes from the next TICK.
REQ-026 PAUSED with START=1 and PAUSE=1: stay in PAUSED (PAUSE has priority).
REQ-027 START in RUN SHALL have no effect.
REQ-028 Q SHALL never hold a non-BCD nibble.
REQ-029 Q SHALL never wrap below 00; it decrements only from nonzero values.
REQ-030 DONE SHALL never be high for two consecutive cycles.
REQ-031 BUSY SHALL be decoded from the registered state only.

Reset
REQ-032 RES=1 at an edge SHALL, regardless of state and of all other inputs, set: Q=00, reload register=00, state IDLE, BUSY=0, DONE=0, ERR=0.
REQ-033 RES asserted mid-count (RUN or PAUSED) SHALL abort the count without producing a DONE pulse.
REQ-034 Control inputs sampled on a reset edge SHALL have no effect.

Verification
REQ-035 LOAD DIN=8'h12, START, TICK held high -> Q sequence 12,11,10,09,...,01,00; DONE high only in the cycle after Q becomes 00; BUSY=0 from then on.
REQ-036 LOAD DIN=8'h3A -> ERR=1 and Q unchanged; then LOAD DIN=8'h05 -> ERR=0 and Q=05.
REQ-037 Q=20, RUN, PAUSE with TICK=1 -> Q holds 20 and state PAUSED; TICK pulses ignored; START -> next TICK gives Q=19.
REQ-038 AUTO_RELOAD=1, LOAD 8'h02, START, TICK continuous -> Q sequence 02,01,00,02,01,00; one DONE pulse per pass; BUSY stays 1.
REQ-039 START with Q=00 -> single DONE pulse, BUSY stays 0.
REQ-040 RES asserted while Q=07 in RUN -> Q=00, BUSY=0 after that edge, and no DONE pulse.
